// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - Buffered 8N1 UART transmitter with DEPTH-entry FIFO
//
// Ports:
//   clk      in   1  system clock
//   rst_n    in   1  reset, asynchronous, active-low
//   trmt     in   1  push strobe: queue tx_data this cycle
//   tx_data  in   8  byte to queue; sampled only when trmt=1
//   TX       out  1  serial line; 1 = idle/mark
//   full     out  1  FIFO holds DEPTH entries (registered)
//   busy     out  1  frame in flight OR FIFO non-empty (registered)
//   tx_done  out  1  1-cycle pulse on the last cycle of each stop bit
//   ovf      out  1  1-cycle pulse (cycle after the push) when a push is dropped
module uart_tx #(
    parameter int BAUD_DIV = 5208,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       full,
    output logic       busy,
    output logic       tx_done,
    output logic       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = 13;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(BAUD_DIV - 1);

    typedef enum logic {
        IDLE,
        XMIT
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic          empty, push, pop;
    logic [7:0]    head;
    logic [9:0]    sr, sr_nxt;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [3:0]    bit_cnt, bit_nxt;
    logic          done_c;
    logic          full_q, busy_q, ovf_q;

    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A push on a full FIFO still fits when the FSM pops in the same cycle.
    assign push       = trmt && (!full_q || pop);
    assign wr_ptr_nxt = wr_ptr + {{(PW-1){1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{(PW-1){1'b0}}, pop};
    assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        pop       = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                sr_nxt = '1;
                if (!empty) begin
                    pop       = 1'b1;
                    sr_nxt    = {1'b1, head, 1'b0};
                    baud_nxt  = BAUD_RELOAD;
                    bit_nxt   = 4'd0;
                    state_nxt = XMIT;
                end
            end
            XMIT: begin
                if (baud_cnt != '0) begin
                    baud_nxt = baud_cnt - 1'b1;
                end else if (bit_cnt != 4'd9) begin
                    sr_nxt   = {1'b1, sr[9:1]};
                    bit_nxt  = bit_cnt + 4'd1;
                    baud_nxt = BAUD_RELOAD;
                end else begin
                    // Last cycle of the stop bit: chain the next frame with no idle gap.
                    done_c = 1'b1;
                    if (!empty) begin
                        pop      = 1'b1;
                        sr_nxt   = {1'b1, head, 1'b0};
                        baud_nxt = BAUD_RELOAD;
                        bit_nxt  = 4'd0;
                    end else begin
                        sr_nxt    = '1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                sr_nxt    = '1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            full_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sr       <= sr_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            full_q   <= (count_nxt == PW'(DEPTH));
            busy_q   <= (state_nxt == XMIT) || (count_nxt != '0);
            ovf_q    <= trmt && full_q && !pop;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    assign TX      = sr[0];
    assign full    = full_q;
    assign busy    = busy_q;
    assign ovf     = ovf_q;
    assign tx_done = done_c;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - Directed self-checking bench for uart_tx (BAUD_DIV=16, DEPTH=4)
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trmt = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       TX, full, busy, tx_done, ovf;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [7:0] rxq [$];
    logic [7:0] exp_q [$];

    uart_tx #(.BAUD_DIV(16), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
        .TX(TX), .full(full), .busy(busy), .tx_done(tx_done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

    // Far-end receiver: detects start, samples mid-bit, keeps bytes with a valid stop bit.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n && TX === 1'b0) begin
                repeat (7) @(negedge clk);
                if (TX === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (16) @(negedge clk);
                        b[i] = TX;
                    end
                    repeat (16) @(negedge clk);
                    if (TX === 1'b1 && rst_n) rxq.push_back(b);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        trmt = 1'b1;
        tx_data = d;
        tick();
        trmt = 1'b0;
    endtask

    // Checks frame cycles start..160 (cycle 1 = first cycle of the start bit).
    task automatic check_frame(input logic [7:0] d, input int start);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        for (int k = start; k <= 160; k++) begin
            chk("frame_tx", TX, f[(k - 1) / 16]);
            chk("frame_done", tx_done, (k == 160) ? 1 : 0);
            tick();
        end
    endtask

    task automatic wait_rx(input int n, input int budget);
        int w;
        w = 0;
        while (rxq.size() < n && w < budget) begin
            tick();
            w++;
        end
        chk("rx_wait_count", rxq.size(), n);
    endtask

    initial begin
        int d0, w;
        logic [7:0] r;

        // Reset held with trmt toggling.
        for (int i = 0; i < 8; i++) begin
            trmt = i[0];
            tx_data = 8'h3C;
            tick();
            chk("rst_tx", TX, 1);
            chk("rst_busy", busy, 0);
            chk("rst_full", full, 0);
            chk("rst_done", tx_done, 0);
            chk("rst_ovf", ovf, 0);
        end
        trmt = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_tx", TX, 1);
        chk("idle_busy", busy, 0);

        // Single byte, tx_data changed after push must not matter.
        d0 = done_cnt;
        push(8'hA5);
        tx_data = 8'hFF;
        chk("single_tx_before_start", TX, 1);
        chk("single_busy_queued", busy, 1);
        tick();
        check_frame(8'hA5, 1);
        chk("single_busy_after", busy, 0);
        chk("single_tx_after", TX, 1);
        chk("single_done_cnt", done_cnt - d0, 1);

        // Back-to-back: frames chained without gap.
        repeat (5) tick();
        d0 = done_cnt;
        rxq.delete();
        trmt = 1'b1;
        tx_data = 8'h00; tick();
        tx_data = 8'hFF; tick();
        tx_data = 8'h55; tick();
        trmt = 1'b0;
        check_frame(8'h00, 2);
        check_frame(8'hFF, 1);
        check_frame(8'h55, 1);
        chk("b2b_busy_after", busy, 0);
        chk("b2b_done_cnt", done_cnt - d0, 3);
        tick();
        chk("b2b_rx_count", rxq.size(), 3);

        // Overflow: 5th push while full is dropped.
        repeat (20) tick();
        rxq.delete();
        push(8'h11);
        tick();
        push(8'h21);
        push(8'h22);
        push(8'h23);
        chk("ovf_not_full_3", full, 0);
        push(8'h24);
        chk("ovf_full_4", full, 1);
        chk("ovf_none_4", ovf, 0);
        push(8'h25);
        chk("ovf_pulse", ovf, 1);
        chk("ovf_still_full", full, 1);
        tick();
        chk("ovf_pulse_end", ovf, 0);
        wait_rx(5, 1000);
        repeat (400) tick();
        chk("ovf_rx_count", rxq.size(), 5);
        exp_q = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24};
        for (int i = 0; i < 5; i++) begin
            r = (i < rxq.size()) ? rxq[i] : 8'hxx;
            chk("ovf_rx_data", r, exp_q[i]);
        end
        chk("ovf_busy_end", busy, 0);

        // Push on full coincident with pop at a frame boundary.
        rxq.delete();
        push(8'h31);
        tick();
        push(8'h32);
        push(8'h33);
        push(8'h34);
        push(8'h35);
        chk("bnd_full", full, 1);
        w = 0;
        while (tx_done !== 1'b1 && w < 300) begin
            tick();
            w++;
        end
        chk("bnd_done_seen", tx_done, 1);
        push(8'h36);
        chk("bnd_full_kept", full, 1);
        chk("bnd_no_ovf", ovf, 0);
        wait_rx(6, 1500);
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        for (int i = 0; i < 6; i++) begin
            r = (i < rxq.size()) ? rxq[i] : 8'hxx;
            chk("bnd_rx_data", r, exp_q[i]);
        end
        repeat (200) tick();
        chk("bnd_busy_end", busy, 0);

        // Reset mid-frame during d3, with more bytes queued.
        push(8'h3C);
        push(8'hC3);
        push(8'h77);
        repeat (70) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", TX, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_full", full, 0);
        for (int i = 0; i < 4; i++) begin
            trmt = i[0];
            tick();
            chk("mid_rst_hold_tx", TX, 1);
        end
        trmt = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            repeat (20) tick();
            chk("post_rst_tx", TX, 1);
            chk("post_rst_busy", busy, 0);
        end
        rxq.delete();
        repeat (300) tick();
        chk("post_rst_no_frames", rxq.size(), 0);
        push(8'h5A);
        tick();
        check_frame(8'h5A, 1);

        // Loopback with random bytes.
        repeat (20) tick();
        rxq.delete();
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            w = 0;
            while (full && w < 400) begin
                tick();
                w++;
            end
            r = 8'($urandom_range(0, 255));
            exp_q.push_back(r);
            push(r);
        end
        wait_rx(256, 2000);
        for (int i = 0; i < 256; i++) begin
            r = (i < rxq.size()) ? rxq[i] : 8'hxx;
            chk("loop_rx_data", r, exp_q[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
